// File: rtl/panda_pkg.sv
// rtl/panda_pkg.sv - shared types for the panda load/store unit
// Purpose: access-size and LSU state encodings used by the LSU and its align helper.
// Ports: none (package).
package panda_pkg;

  typedef enum logic [1:0] {
    MemByte    = 2'b00,
    MemHalf    = 2'b01,
    MemWord    = 2'b10,
    MemIllegal = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    LsuIdle = 2'b00,
    LsuWait = 2'b01,
    LsuResp = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/panda_lsu_align.sv
// rtl/panda_lsu_align.sv - load data lane extraction and sign/zero extension
// Purpose: pick the addressed byte/half out of a 32-bit RAM word and extend it.
// Ports:
//   rdata       in  32  raw RAM word
//   offset      in  2   byte offset within the word
//   size        in  2   access size (mem_size_e)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   data        out 32  formatted load data
module panda_lsu_align
  import panda_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (offset)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    // Halves are aligned, so only offset[1] selects the lane.
    half_v = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (size)
      MemByte: data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      MemHalf: data = {{16{~is_unsigned & half_v[15]}}, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/panda_lsu.sv
// rtl/panda_lsu.sv - single-outstanding load/store unit in front of the data RAM
// Purpose: accept one request, drive the byte-enabled RAM, format load data, return a response.
// Ports:
//   clk_i, rst_i                          clock, synchronous active-high reset
//   req_valid_i/req_ready_o               request handshake
//   req_we_i, req_size_i, req_unsigned_i  request kind
//   req_addr_i, req_wdata_i               byte address, right-aligned store data
//   rsp_valid_o/rsp_ready_i               response handshake
//   rsp_rdata_o, rsp_err_o                formatted load data, access error
//   ram_ce_o, ram_we_o, ram_addr_o        RAM control and word address
//   ram_wdata_o, ram_rdata_i              RAM data
module panda_lsu
  import panda_pkg::*;
#(
  parameter int         AddrWidth    = 32,
  parameter int         Depth        = 1024,
  parameter logic       RamOutputReg = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [1:0]               req_size_i,
  input  logic                     req_unsigned_i,
  input  logic [AddrWidth-1:0]     req_addr_i,
  input  logic [31:0]              req_wdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic                     ram_ce_o,
  output logic [3:0]               ram_we_o,
  output logic [$clog2(Depth)-1:0] ram_addr_o,
  output logic [31:0]              ram_wdata_o,
  input  logic [31:0]              ram_rdata_i
);

  localparam int IdxW = $clog2(Depth);

  lsu_state_e state;
  mem_size_e  req_size;
  mem_size_e  lat_size;
  logic [1:0] lat_off;
  logic       lat_uns;

  logic                 accept;
  logic                 req_err;
  logic [AddrWidth-1:0] addr_hi;
  logic [3:0]           be;
  logic [31:0]          fmt_data;

  assign req_size    = mem_size_e'(req_size_i);
  assign req_ready_o = (state == LsuIdle);
  assign accept      = req_valid_i && (state == LsuIdle) && !rst_i;

  // Any address bit above the RAM's byte range makes the access out of range.
  assign addr_hi = req_addr_i >> (IdxW + 2);

  always_comb begin
    req_err = 1'b0;
    if (req_size == MemIllegal)                             req_err = 1'b1;
    if (req_size == MemHalf && req_addr_i[0])               req_err = 1'b1;
    if (req_size == MemWord && req_addr_i[1:0] != 2'b00)    req_err = 1'b1;
    if (|addr_hi)                                           req_err = 1'b1;
  end

  always_comb begin
    be          = 4'b1111;
    ram_wdata_o = req_wdata_i;
    case (req_size)
      MemByte: begin
        be          = 4'b0001 << req_addr_i[1:0];
        ram_wdata_o = {4{req_wdata_i[7:0]}};
      end
      MemHalf: begin
        be          = 4'b0011 << req_addr_i[1:0];
        ram_wdata_o = {2{req_wdata_i[15:0]}};
      end
      default: begin
        be          = 4'b1111;
        ram_wdata_o = req_wdata_i;
      end
    endcase
  end

  // The RAM is only touched in the accept cycle of a legal request.
  assign ram_ce_o   = accept && !req_err;
  assign ram_we_o   = (ram_ce_o && req_we_i) ? be : 4'b0000;
  assign ram_addr_o = req_addr_i[IdxW+1:2];

  // Without an output register the data arrives in the accept cycle, so format
  // from the live request; otherwise from the fields latched at accept.
  panda_lsu_align u_align (
    .rdata       (ram_rdata_i),
    .offset      (RamOutputReg ? lat_off  : req_addr_i[1:0]),
    .size        (RamOutputReg ? lat_size : req_size),
    .is_unsigned (RamOutputReg ? lat_uns  : req_unsigned_i),
    .data        (fmt_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= LsuIdle;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= 32'h0;
      lat_off     <= 2'b00;
      lat_size    <= MemByte;
      lat_uns     <= 1'b0;
    end else begin
      case (state)
        LsuIdle: begin
          if (req_valid_i) begin
            lat_off  <= req_addr_i[1:0];
            lat_size <= req_size;
            lat_uns  <= req_unsigned_i;
            if (req_err || req_we_i) begin
              state       <= LsuResp;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= req_err;
              rsp_rdata_o <= 32'h0;
            end else if (RamOutputReg) begin
              state <= LsuWait;
            end else begin
              state       <= LsuResp;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b0;
              rsp_rdata_o <= fmt_data;
            end
          end
        end
        LsuWait: begin
          state       <= LsuResp;
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= fmt_data;
        end
        LsuResp: begin
          if (rsp_ready_i) begin
            state       <= LsuIdle;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= 32'h0;
          end
        end
        default: state <= LsuIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_panda_lsu.sv
// tb/tb_panda_lsu.sv - directed scoreboard bench for panda_lsu, both RAM output modes
module tb_panda_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;          // 1 = observe/drive registered-RAM instance, 0 = flow-through instance
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        rdy1, vld1, err1, ce1, rdy0, vld0, err0, ce0;
  logic [31:0] rd1, wd1, rd0, wd0, ramrd1, ramrd0;
  logic [3:0]  we1, we0;
  logic [9:0]  ad1, ad0;

  logic [31:0] mem1 [1024];
  logic [31:0] mem0 [1024];

  panda_lsu #(.AddrWidth(32), .Depth(1024), .RamOutputReg(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid & sel), .req_ready_o(rdy1),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(vld1), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd1), .rsp_err_o(err1),
    .ram_ce_o(ce1), .ram_we_o(we1), .ram_addr_o(ad1), .ram_wdata_o(wd1), .ram_rdata_i(ramrd1)
  );

  panda_lsu #(.AddrWidth(32), .Depth(1024), .RamOutputReg(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid & ~sel), .req_ready_o(rdy0),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(vld0), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd0), .rsp_err_o(err0),
    .ram_ce_o(ce0), .ram_we_o(we0), .ram_addr_o(ad0), .ram_wdata_o(wd0), .ram_rdata_i(ramrd0)
  );

  // RAM models: registered-output and flow-through, byte-enabled writes.
  always @(posedge clk) begin
    if (ce1) begin
      for (int b = 0; b < 4; b++) if (we1[b]) mem1[ad1][b*8 +: 8] <= wd1[b*8 +: 8];
      if (we1 == 4'b0000) ramrd1 <= mem1[ad1];
    end
    if (ce0) begin
      for (int b = 0; b < 4; b++) if (we0[b]) mem0[ad0][b*8 +: 8] <= wd0[b*8 +: 8];
    end
  end
  assign ramrd0 = mem0[ad0];

  wire        o_rdy   = sel ? rdy1 : rdy0;
  wire        o_vld   = sel ? vld1 : vld0;
  wire        o_err   = sel ? err1 : err0;
  wire        o_ce    = sel ? ce1  : ce0;
  wire [31:0] o_rd    = sel ? rd1  : rd0;
  wire [31:0] o_wd    = sel ? wd1  : wd0;
  wire [3:0]  o_we    = sel ? we1  : we0;
  wire [9:0]  o_ad    = sel ? ad1  : ad0;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s (ram_reg=%0d): observed %h expected %h", tag, sel, obs, exp);
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_err, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                     input bit stall);
    int lat;
    int exp_lat;
    logic [32:0] e;
    logic [31:0] held;
    exp_lat = (exp_err || we) ? 1 : (sel ? 2 : 1);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_uns = uns;
    req_addr = addr; req_wdata = wd; rsp_ready = !stall;
    #1;
    chk({tag, ".req_ready"}, 32'(o_rdy), 32'd1);
    if (exp_err) begin
      chk({tag, ".ce_err"}, 32'(o_ce), 32'd0);
    end else begin
      chk({tag, ".ce"}, 32'(o_ce), 32'd1);
      chk({tag, ".we"}, 32'(o_we), 32'(exp_be));
      chk({tag, ".addr"}, 32'(o_ad), 32'(addr[11:2]));
      if (we) chk({tag, ".wdata"}, o_wd, exp_wd);
    end
    sb.push_back({exp_err, exp_rd});
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (o_vld) break;
      chk({tag, ".ce_wait"}, 32'(o_ce), 32'd0);
      chk({tag, ".ready_wait"}, 32'(o_rdy), 32'd0);
    end
    chk({tag, ".latency"}, lat, exp_lat);
    if (o_vld) begin
      e = sb.pop_front();
      chk({tag, ".rdata"}, o_rd, e[31:0]);
      chk({tag, ".err"}, 32'(o_err), 32'(e[32]));
      held = o_rd;
      if (stall) begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk({tag, ".stall_valid"}, 32'(o_vld), 32'd1);
          chk({tag, ".stall_rdata"}, o_rd, held);
          chk({tag, ".stall_ready"}, 32'(o_rdy), 32'd0);
          chk({tag, ".stall_ce"}, 32'(o_ce), 32'd0);
        end
        rsp_ready = 1'b1;
      end
      @(negedge clk);
      chk({tag, ".done_valid"}, 32'(o_vld), 32'd0);
      chk({tag, ".done_ready"}, 32'(o_rdy), 32'd1);
    end else begin
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_uns = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int s = 1; s >= 0; s--) begin
      sel = s[0];
      @(negedge clk);
      chk("reset.valid", 32'(o_vld), 32'd0);
      chk("reset.err", 32'(o_err), 32'd0);
      chk("reset.rdata", o_rd, 32'd0);
      chk("reset.ready", 32'(o_rdy), 32'd1);
      chk("reset.ce", 32'(o_ce), 32'd0);

      txn("st_w",   1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'hDEADBEEF, 0);
      txn("ld_w",   0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 4'b0000, 32'h0, 0);
      txn("st_b",   1, 2'b00, 0, 32'h13, 32'h00000080, 32'h0,        0, 4'b1000, 32'h80808080, 0);
      txn("ld_bs",  0, 2'b00, 0, 32'h13, 32'h0,        32'hFFFFFF80, 0, 4'b0000, 32'h0, 0);
      txn("ld_bu",  0, 2'b00, 1, 32'h13, 32'h0,        32'h00000080, 0, 4'b0000, 32'h0, 0);
      txn("ld_w2",  0, 2'b10, 0, 32'h10, 32'h0,        32'h80ADBEEF, 0, 4'b0000, 32'h0, 0);
      txn("st_w2",  1, 2'b10, 0, 32'h10, 32'h80017FFF, 32'h0,        0, 4'b1111, 32'h80017FFF, 0);
      txn("ld_hs",  0, 2'b01, 0, 32'h12, 32'h0,        32'hFFFF8001, 0, 4'b0000, 32'h0, 0);
      txn("ld_hu",  0, 2'b01, 1, 32'h10, 32'h0,        32'h00007FFF, 0, 4'b0000, 32'h0, 0);
      txn("st_h",   1, 2'b01, 0, 32'h16, 32'h1234A5C3, 32'h0,        0, 4'b1100, 32'hA5C3A5C3, 0);
      txn("ld_h16", 0, 2'b01, 1, 32'h16, 32'h0,        32'h0000A5C3, 0, 4'b0000, 32'h0, 0);
      txn("e_half", 0, 2'b01, 0, 32'h11, 32'h0,        32'h0,        1, 4'b0000, 32'h0, 0);
      txn("e_word", 1, 2'b10, 0, 32'h12, 32'h5555AAAA, 32'h0,        1, 4'b0000, 32'h0, 0);
      txn("e_size", 0, 2'b11, 0, 32'h00, 32'h0,        32'h0,        1, 4'b0000, 32'h0, 0);
      txn("e_rng",  0, 2'b10, 0, 32'h1000, 32'h0,      32'h0,        1, 4'b0000, 32'h0, 0);
      txn("ld_bp",  0, 2'b10, 0, 32'h10, 32'h0,        32'h80017FFF, 0, 4'b0000, 32'h0, 1);

      // Reset right after accepting a load (WAIT for the registered RAM).
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0; req_addr = 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid.valid", 32'(o_vld), 32'd0);
      chk("rst_mid.ready", 32'(o_rdy), 32'd1);
      chk("rst_mid.ce", 32'(o_ce), 32'd0);
      txn("ld_post", 0, 2'b10, 0, 32'h10, 32'h0, 32'h80017FFF, 0, 4'b0000, 32'h0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
